// File: rtl/lsu_wb_pkg.sv
// rtl/lsu_wb_pkg.sv - shared funct3 codes, FSM state type and lane helpers for the LSU
// Contents:
//   LSU_B/H/W/BU/HU  load/store size codes (RISC-V funct3)
//   lsu_state_t      LSU FSM states (IDLE, REQ, WAIT, WB)
//   is_byte/is_half  size classification; reserved codes classify as word
//   byte_en          byte-enable pattern for a size and low address bits
//   store_data       lane-replicated store data
package lsu_wb_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lsu_state_t;

    function automatic logic is_byte(input logic [2:0] size);
        return (size == LSU_B) || (size == LSU_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] size);
        return (size == LSU_H) || (size == LSU_HU);
    endfunction

    // Halfwords only look at addr[1]; bit 0 is ignored so the access
    // always lands on a naturally aligned lane pair.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LSU_B, LSU_BU: return 4'b0001 << off;
            LSU_H, LSU_HU: return off[1] ? 4'b1100 : 4'b0011;
            LSU_W:         return 4'b1111;
            default:       return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wdata);
        if (is_byte(size)) begin
            return {4{wdata[7:0]}};
        end else if (is_half(size)) begin
            return {2{wdata[15:0]}};
        end
        return wdata;
    endfunction

endpackage

// File: rtl/lsu_wb_if.sv
// rtl/lsu_wb_if.sv - data-memory req/gnt/rvalid bus between the LSU and memory
// Signals:
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  request side, driven by the LSU (master)
//   mem_gnt/mem_rvalid/mem_rdata              response side, driven by memory (slave)
interface lsu_wb_if #(
    parameter int AW = 32
) ();

    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_wb_extend.sv
// rtl/lsu_wb_extend.sv - load lane select and sign/zero extension (combinational)
// Ports:
//   rdata  in   32  raw memory word
//   off    in   2   byte offset of the access (addr[1:0])
//   size   in   3   funct3 of the load
//   data   out  32  value to write back
module lsu_wb_extend
    import lsu_wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        // size[2] distinguishes the unsigned variants (BU/HU)
        if (is_byte(size)) begin
            data = size[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        end else if (is_half(size)) begin
            data = size[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        end
    end

endmodule

// File: rtl/lsu_wb.sv
// rtl/lsu_wb.sv - load/store unit with register-file writeback port
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/HU/W instead of forcing alignment)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_i/st_i/size_i        memory op from decode (store flag, funct3)
//   addr_i/wdata_i/rd_i      byte address, store data, load destination
//   stall_o                  hold decode/PC
//   mem                      data-memory bus (lsu_wb_if.master)
//   wa/wd/we                 register file write port, we is a one-cycle pulse
//   misalign_o               misaligned-access pulse (0 unless the trap is built in)
module lsu_wb
    import lsu_wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    input  logic          st_i,
    input  logic [2:0]    size_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [4:0]    rd_i,
    output logic          stall_o,
    lsu_wb_if.master      mem,
    output logic [4:0]    wa,
    output logic [DW-1:0] wd,
    output logic          we,
    output logic          misalign_o
);

    lsu_state_t  state, state_n;
    logic        st_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        trap;
    logic        accept;
    logic [31:0] ext_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = req_i && (is_half(size_i) ? addr_i[0]
                                            : (!is_byte(size_i) && (addr_i[1:0] != 2'b00)));

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= (state == IDLE) && trap;
        end
    end
`else
    assign trap       = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // A trapped op is dropped in IDLE: no capture, no request.
    assign accept  = (state == IDLE) && req_i && !trap;
    assign stall_o = req_i || (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        we          = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_n = REQ;
            end
            REQ: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = st_q;
                if (mem.mem_gnt) state_n = st_q ? IDLE : WAIT;
            end
            WAIT: begin
                // rvalid is only honoured here, never in the grant cycle
                if (mem.mem_rvalid) state_n = WB;
            end
            WB: begin
                we      = (wa != 5'd0);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request fields are registered at acceptance so they stay stable while waiting for gnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q          <= 1'b0;
            size_q        <= 3'b000;
            off_q         <= 2'b00;
            rd_q          <= 5'd0;
            mem.mem_be    <= 4'b0000;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= 32'h0;
            wa            <= 5'd0;
            wd            <= '0;
        end else begin
            if (accept) begin
                st_q          <= st_i;
                size_q        <= size_i;
                off_q         <= addr_i[1:0];
                rd_q          <= rd_i;
                mem.mem_be    <= byte_en(size_i, addr_i[1:0]);
                mem.mem_addr  <= {addr_i[AW-1:2], 2'b00};
                mem.mem_wdata <= store_data(size_i, wdata_i);
            end
            if ((state == WAIT) && mem.mem_rvalid) begin
                wa <= rd_q;
                wd <= ext_data;
            end
        end
    end

    lsu_wb_extend u_extend (
        .rdata (mem.mem_rdata),
        .off   (off_q),
        .size  (size_q),
        .data  (ext_data)
    );

endmodule

// File: tb/tb_lsu_wb.sv
// tb/tb_lsu_wb.sv - scoreboard bench for lsu_wb with a delayed-grant memory responder
module tb_lsu_wb;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        st_i;
    logic [2:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic        misalign_o;

    lsu_wb_if mem_bus ();

    lsu_wb dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .st_i       (st_i),
        .size_i     (size_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rd_i       (rd_i),
        .stall_o    (stall_o),
        .mem        (mem_bus.master),
        .wa         (wa),
        .wd         (wd),
        .we         (we),
        .misalign_o (misalign_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        int          issue;
        int          lat;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int we_cnt = 0;
    int mis_cnt = 0;

    int          gnt_delay = 0;
    int          rv_delay = 1;
    logic [31:0] rdata_cfg = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Memory model: grant after gnt_delay cycles of mem_req, rvalid rv_delay cycles after a load grant.
    initial begin : responder
        int g_cnt;
        int rv_cnt;
        g_cnt = 0;
        rv_cnt = 0;
        mem_bus.mem_gnt = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_bus.mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_bus.mem_rvalid = 1'b1;
                    mem_bus.mem_rdata = rdata_cfg;
                end
            end
            mem_bus.mem_gnt = 1'b0;
            if (mem_bus.mem_req) begin
                if (g_cnt >= gnt_delay) begin
                    mem_bus.mem_gnt = 1'b1;
                    g_cnt = 0;
                    if (!mem_bus.mem_we) rv_cnt = rv_delay;
                end else begin
                    g_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        req_t r;
        wb_t  w;
        if (!rst && mem_bus.mem_req && mem_bus.mem_gnt) begin
            total++;
            if (req_q.size() == 0) begin
                bad++;
                $display("FAIL mem_req unexpected: addr=%h be=%b", mem_bus.mem_addr, mem_bus.mem_be);
            end else begin
                r = req_q.pop_front();
                if (mem_bus.mem_we !== r.we || mem_bus.mem_addr !== r.addr ||
                    mem_bus.mem_be !== r.be || mem_bus.mem_wdata !== r.wdata) begin
                    bad++;
                    $display("FAIL mem_req: got we=%b addr=%h be=%b wdata=%h, want we=%b addr=%h be=%b wdata=%h",
                             mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata,
                             r.we, r.addr, r.be, r.wdata);
                end
            end
        end
        if (we) begin
            we_cnt++;
            total++;
            if (wb_q.size() == 0) begin
                bad++;
                $display("FAIL writeback unexpected: wa=%0d wd=%h", wa, wd);
            end else begin
                w = wb_q.pop_front();
                if (wa !== w.wa || wd !== w.wd || (cyc - w.issue) != w.lat) begin
                    bad++;
                    $display("FAIL writeback: got wa=%0d wd=%h lat=%0d, want wa=%0d wd=%h lat=%0d",
                             wa, wd, cyc - w.issue, w.wa, w.wd, w.lat);
                end
            end
        end
        if (misalign_o) mis_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic do_op(input logic st, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         input int gd, input logic exp_req, input logic [31:0] e_addr,
                         input logic [3:0] e_be, input logic [31:0] e_wdata, input logic [31:0] e_wd,
                         input int e_stall, input int e_reqc);
        int n;
        int rq;
        bit done;
        gnt_delay = gd;
        rdata_cfg = rdata;
        @(posedge clk);
        #1;
        if (exp_req) req_q.push_back('{st, e_addr, e_be, e_wdata});
        if (exp_req && !st && rd != 5'd0) wb_q.push_back('{rd, e_wd, cyc, 3 + gd});
        req_i = 1'b1;
        st_i = st;
        size_i = size;
        addr_i = addr;
        wdata_i = wdata;
        rd_i = rd;
        n = 0;
        rq = 0;
        done = 1'b0;
        @(negedge clk);
        if (stall_o) n++;
        if (mem_bus.mem_req) rq++;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (mem_bus.mem_req) rq++;
            if (stall_o) n++;
            else done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL op_timeout: stall_o still high after 60 cycles, addr=%h", addr);
        end
        chk("stall_cycles", n, e_stall);
        chk("req_cycles", rq, e_reqc);
    endtask

    initial begin : stim
        int we_before;
        rst = 1'b1;
        req_i = 1'b0;
        st_i = 1'b0;
        size_i = 3'b000;
        addr_i = 32'h0;
        wdata_i = 32'h0;
        rd_i = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset_stall", stall_o, 0);
        chk("reset_mem_req", mem_bus.mem_req, 0);
        chk("reset_mem_we", mem_bus.mem_we, 0);
        chk("reset_mem_be", mem_bus.mem_be, 0);
        chk("reset_mem_addr", mem_bus.mem_addr, 0);
        chk("reset_mem_wdata", mem_bus.mem_wdata, 0);
        chk("reset_we", we, 0);
        chk("reset_wa", wa, 0);
        chk("reset_wd", wd, 0);
        chk("reset_misalign", misalign_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // st size addr wdata rd rdata gd | req addr be wdata wd stall reqc
        do_op(0, 3'b010, 32'h100, 0, 5, 32'hDEADBEEF, 0, 1, 32'h100, 4'hF, 0, 32'hDEADBEEF, 4, 1);
        do_op(0, 3'b000, 32'h103, 0, 6, 32'h80112233, 0, 1, 32'h100, 4'h8, 0, 32'hFFFFFF80, 4, 1);
        do_op(0, 3'b100, 32'h103, 0, 6, 32'h80112233, 0, 1, 32'h100, 4'h8, 0, 32'h00000080, 4, 1);
        do_op(0, 3'b001, 32'h102, 0, 6, 32'h80112233, 0, 1, 32'h100, 4'hC, 0, 32'hFFFF8011, 4, 1);
        do_op(0, 3'b101, 32'h100, 0, 10, 32'h7654ABCD, 0, 1, 32'h100, 4'h3, 0, 32'h0000ABCD, 4, 1);
        do_op(0, 3'b000, 32'h100, 0, 11, 32'h7654ABCD, 0, 1, 32'h100, 4'h1, 0, 32'hFFFFFFCD, 4, 1);
        do_op(0, 3'b100, 32'h101, 0, 12, 32'h7654ABCD, 2, 1, 32'h100, 4'h2, 0, 32'h000000AB, 6, 3);
        do_op(0, 3'b110, 32'h108, 0, 13, 32'h0BADF00D, 0, 1, 32'h108, 4'hF, 0, 32'h0BADF00D, 4, 1);

        we_before = we_cnt;
        do_op(1, 3'b000, 32'h201, 32'h000000AB, 3, 0, 3, 1, 32'h200, 4'h2, 32'hABABABAB, 0, 5, 4);
        do_op(1, 3'b001, 32'h102, 32'h1234CDEF, 0, 0, 0, 1, 32'h100, 4'hC, 32'hCDEFCDEF, 0, 2, 1);
        do_op(1, 3'b010, 32'h300, 32'h11223344, 0, 0, 1, 1, 32'h300, 4'hF, 32'h11223344, 0, 3, 2);
        do_op(0, 3'b010, 32'h104, 0, 0, 32'hCAFEF00D, 1, 1, 32'h104, 4'hF, 0, 0, 5, 2);
        repeat (3) @(negedge clk);
        chk("store_and_x0_no_we", we_cnt - we_before, 0);

        // Reset lands while the load waits in WAIT; its rvalid arrives after reset.
        gnt_delay = 0;
        rv_delay = 2;
        rdata_cfg = 32'h55AA55AA;
        @(posedge clk);
        #1;
        req_q.push_back('{1'b0, 32'h400, 4'hF, 32'h0});
        req_i = 1'b1;
        st_i = 1'b0;
        size_i = 3'b010;
        addr_i = 32'h400;
        wdata_i = 32'h0;
        rd_i = 5'd7;
        we_before = we_cnt;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_stall", stall_o, 0);
        chk("rst_wait_mem_req", mem_bus.mem_req, 0);
        chk("rst_wait_wa", wa, 0);
        repeat (4) @(negedge clk);
        chk("rst_wait_no_we", we_cnt - we_before, 0);
        chk("rst_wait_wd", wd, 0);
        rv_delay = 1;

`ifdef LSU_MISALIGN_TRAP_EN
        do_op(0, 3'b010, 32'h102, 0, 9, 32'h12345678, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) @(negedge clk);
        chk("misalign_pulses", mis_cnt, 1);
`else
        do_op(0, 3'b010, 32'h102, 0, 9, 32'h12345678, 0, 1, 32'h100, 4'hF, 0, 32'h12345678, 4, 1);
        repeat (2) @(negedge clk);
        chk("misalign_pulses", mis_cnt, 0);
`endif

        chk("req_queue_drained", req_q.size(), 0);
        chk("wb_queue_drained", wb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
